// File: rtl/nand_logic_pipe.sv
// -----------------------------------------------------------------------------
// nand_logic_pipe
//   Two-stage pipelined WIDTH-bit logic unit whose eight functions are all
//   composed from 2-input NAND cells. Stage 1 captures the operands together
//   with the three first-level NAND products; stage 2 forms the final result.
//   Both ends use valid/ready handshakes. A counter tallies delivered results.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   a, b and op are valid this cycle
//   in_ready   out  operands are accepted this cycle
//   a, b       in   WIDTH-bit operands
//   op         in   function select (see op_e)
//   out_valid  out  q is valid
//   out_ready  in   sink accepts q this cycle
//   q          out  WIDTH-bit result
//   q_zero     out  q is all zeros (meaningful only with out_valid)
//   res_count  out  completed output handshakes, wraps at 2^CNT_W
// -----------------------------------------------------------------------------
module nand_logic_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] q,
    output logic             q_zero,
    output logic [CNT_W-1:0] res_count
);

    typedef enum logic [2:0] {
        OP_NAND = 3'b000,
        OP_AND  = 3'b001,
        OP_OR   = 3'b010,
        OP_NOR  = 3'b011,
        OP_XOR  = 3'b100,
        OP_XNOR = 3'b101,
        OP_NOTA = 3'b110,
        OP_PASS = 3'b111
    } op_e;

    // The one primitive cell every function is built from.
    function automatic logic [WIDTH-1:0] nand2(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y);
        return ~(x & y);
    endfunction

    // Stage 1 payload
    logic [WIDTH-1:0] s1_a_q, s1_b_q, s1_n_q, s1_na_q, s1_nb_q;
    op_e              s1_op_q;
    logic             s1_valid_q, s1_valid_d;

    // Stage 2 / output
    logic [WIDTH-1:0] q_q, q_d;
    logic             q_zero_q, q_zero_d;
    logic             s2_valid_q, s2_valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic s1_load, s2_load;

    // ---------------------------------------------------------------- flow
    // Stage 2 takes stage 1's item when it is empty or emptying this cycle,
    // which lets a full pipeline keep accepting input at one item per cycle.
    assign s2_load  = s1_valid_q & (~s2_valid_q | out_ready);
    assign in_ready = ~s1_valid_q | s2_load;
    assign s1_load  = in_valid & in_ready;

    assign s1_valid_d = s1_load | (s1_valid_q & ~s2_load);
    assign s2_valid_d = s2_load | (s2_valid_q & ~out_ready);
    assign cnt_d      = (s2_valid_q & out_ready) ? cnt_q + CNT_W'(1) : cnt_q;

    // ------------------------------------------------------------- stage 1
    // NOTE: payload flops carry no reset; s1_valid_q qualifies them, so their
    // power-up contents are never observed and the reset net stays small.
    always_ff @(posedge clk) begin
        if (s1_load) begin
            s1_a_q  <= a;
            s1_b_q  <= b;
            s1_op_q <= op_e'(op);
            s1_n_q  <= nand2(a, b);
            s1_na_q <= nand2(a, a);
            s1_nb_q <= nand2(b, b);
        end
    end

    // ------------------------------------------------------- stage 2 logic
    logic [WIDTH-1:0] and_w, or_w, xor_w;

    assign and_w = nand2(s1_n_q, s1_n_q);
    assign or_w  = nand2(s1_na_q, s1_nb_q);
    assign xor_w = nand2(nand2(s1_a_q, s1_n_q), nand2(s1_b_q, s1_n_q));

    // NOTE: q_d gets a value before the case so no path through this block
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        q_d = s1_n_q;
        unique case (s1_op_q)
            OP_NAND: q_d = s1_n_q;
            OP_AND:  q_d = and_w;
            OP_OR:   q_d = or_w;
            OP_NOR:  q_d = nand2(or_w, or_w);
            OP_XOR:  q_d = xor_w;
            OP_XNOR: q_d = nand2(xor_w, xor_w);
            OP_NOTA: q_d = s1_na_q;
            OP_PASS: q_d = nand2(s1_na_q, s1_na_q);
        endcase
    end

    assign q_zero_d = ~|q_d;

    // ------------------------------------------------------ control state
    // NOTE: state flops use non-blocking assignment so each one samples the
    // pre-edge value of the others regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            q_q        <= '0;
            q_zero_q   <= 1'b1;
            cnt_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            cnt_q      <= cnt_d;
            if (s2_load) begin
                q_q      <= q_d;
                q_zero_q <= q_zero_d;
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign q         = q_q;
    assign q_zero    = q_zero_q;
    assign res_count = cnt_q;

endmodule

// File: tb/tb_nand_logic_pipe.sv
// -----------------------------------------------------------------------------
// tb_nand_logic_pipe
//   Directed scenarios followed by randomized traffic. Two instances share
//   the stimulus: one with the default counter width, one with CNT_W=4 for
//   the wrap case. Expected behaviour comes from an in-order item queue
//   where each entry remembers the clock edge that accepted it.
// -----------------------------------------------------------------------------
module tb_nand_logic_pipe;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] a = '0, b = '0;
    logic [2:0] op = '0;

    logic        in_ready, out_valid, q_zero;
    logic [7:0]  q;
    logic [15:0] res_count;
    logic        in_ready4, out_valid4, q_zero4;
    logic [7:0]  q4;
    logic [3:0]  res_count4;

    always #5 clk = ~clk;

    nand_logic_pipe #(.WIDTH(8), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .q(q), .q_zero(q_zero), .res_count(res_count)
    );

    nand_logic_pipe #(.WIDTH(8), .CNT_W(4)) dut_w4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
        .a(a), .b(b), .op(op), .out_valid(out_valid4), .out_ready(out_ready),
        .q(q4), .q_zero(q_zero4), .res_count(res_count4)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // ------------------------------------------------------ reference model
    typedef struct {
        logic [7:0] d;
        int         e;   // edge index at which the item was accepted
    } item_t;

    item_t      pipe_q[$];
    logic [7:0] log_q[$];   // observed q of every delivered result
    int         edge_n = 0;
    int         cnt16 = 0, cnt4 = 0;

    function automatic logic [7:0] ref_fn(input logic [2:0] f, input logic [7:0] x, input logic [7:0] y);
        case (f)
            3'd0: return ~(x & y);
            3'd1: return x & y;
            3'd2: return x | y;
            3'd3: return ~(x | y);
            3'd4: return x ^ y;
            3'd5: return ~(x ^ y);
            3'd6: return ~x;
            default: return x;
        endcase
    endfunction

    // One clock: check outputs at the falling edge, advance the model at the
    // rising edge, return 1 ns later so the caller can drive new inputs.
    task automatic tick(output logic in_hs);
        logic exp_ir, exp_ov, out_hs;
        logic [7:0] q_seen;
        @(negedge clk);
        exp_ov = (pipe_q.size() > 0) && (pipe_q[0].e + 1 < edge_n);
        exp_ir = (pipe_q.size() < 2) || out_ready;
        check("in_ready",     32'(in_ready),   32'(exp_ir));
        check("out_valid",    32'(out_valid),  32'(exp_ov));
        check("out_valid_w4", 32'(out_valid4), 32'(exp_ov));
        check("res_count",    32'(res_count),  cnt16);
        check("res_count_w4", 32'(res_count4), cnt4);
        if (exp_ov) begin
            check("q",      32'(q),      32'(pipe_q[0].d));
            check("q_zero", 32'(q_zero), 32'(pipe_q[0].d == 8'h00));
            check("q_w4",   32'(q4),     32'(pipe_q[0].d));
        end
        q_seen = q;
        in_hs  = in_valid && exp_ir;
        out_hs = exp_ov && out_ready;
        @(posedge clk);
        if (out_hs) begin
            log_q.push_back(q_seen);
            void'(pipe_q.pop_front());
            cnt16 = (cnt16 + 1) % 65536;
            cnt4  = (cnt4 + 1) % 16;
        end
        if (in_hs) pipe_q.push_back('{d: ref_fn(op, a, b), e: edge_n});
        edge_n++;
        #1;
    endtask

    task automatic ticks(input int n);
        logic hs;
        for (int i = 0; i < n; i++) tick(hs);
    endtask

    // Called 1 ns after a rising edge, so reset toggles between edges.
    task automatic pulse_reset();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #2;
        check("rst_out_valid",  32'(out_valid),  32'd0);
        check("rst_in_ready",   32'(in_ready),   32'd1);
        check("rst_q",          32'(q),          32'd0);
        check("rst_q_zero",     32'(q_zero),     32'd1);
        check("rst_res_count",  32'(res_count),  32'd0);
        check("rst_res_cnt_w4", 32'(res_count4), 32'd0);
        pipe_q.delete();
        cnt16 = 0;
        cnt4  = 0;
        #1 rst_n = 1'b1;
    endtask

    task automatic check_log(input string tag, input logic [7:0] exp[$]);
        check({tag, "_len"}, log_q.size(), exp.size());
        for (int i = 0; i < exp.size() && i < log_q.size(); i++)
            check($sformatf("%s_%0d", tag, i), 32'(log_q[i]), 32'(exp[i]));
    endtask

    logic       hs;
    logic [7:0] exp_ops[$];
    int         guard;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        pulse_reset();

        // Single NAND item, latency and count
        out_ready = 1'b1;
        in_valid = 1'b1; a = 8'hF0; b = 8'hCC; op = 3'b000;
        tick(hs);
        in_valid = 1'b0; a = 8'h00; b = 8'h00; op = 3'b111;
        ticks(1);
        check("t1_valid_at_2", 32'(out_valid), 32'd1);
        check("t1_q",          32'(q),         32'h3F);
        ticks(2);
        check("t1_count",      32'(res_count), 32'd1);

        // All eight functions back to back
        pulse_reset();
        log_q.delete();
        in_valid = 1'b1; a = 8'hF0; b = 8'hCC;
        for (int i = 0; i < 8; i++) begin
            op = 3'(i);
            tick(hs);
        end
        in_valid = 1'b0;
        ticks(3);
        exp_ops = '{8'h3F, 8'hC0, 8'hFC, 8'h03, 8'h3C, 8'hC3, 8'h0F, 8'hF0};
        check_log("ops", exp_ops);
        check("ops_count", 32'(res_count), 32'd8);

        // OR built from NANDs, including the all-zero result
        log_q.delete();
        in_valid = 1'b1; op = 3'b010;
        a = 8'h00; b = 8'h00; tick(hs);
        a = 8'h01; b = 8'h80; tick(hs);
        in_valid = 1'b0;
        ticks(3);
        exp_ops = '{8'h00, 8'h81};
        check_log("or", exp_ops);

        // Stall: two items fill the pipe, the third waits for the sink
        pulse_reset();
        log_q.delete();
        out_ready = 1'b0;
        in_valid = 1'b1;
        a = 8'hF0; b = 8'hCC; op = 3'd0; tick(hs);
        a = 8'hAA; b = 8'h55; op = 3'd4; tick(hs);
        a = 8'h12; b = 8'h34; op = 3'd1;
        ticks(3);
        check("stall_in_ready", 32'(in_ready), 32'd0);
        check("stall_q_held",   32'(q),        32'h3F);
        out_ready = 1'b1;
        guard = 0;
        do begin
            tick(hs);
            guard++;
        end while (!hs && guard < 10);
        check("stall_accept_timeout", 32'(hs), 32'd1);
        in_valid = 1'b0;
        ticks(4);
        exp_ops = '{8'h3F, 8'hFF, 8'h10};
        check_log("stall", exp_ops);

        // Counter wrap on the 4-bit instance
        pulse_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 17; i++) begin
            a = 8'($urandom); b = 8'($urandom); op = 3'($urandom);
            tick(hs);
        end
        in_valid = 1'b0;
        ticks(3);
        check("wrap_w4",  32'(res_count4), 32'd1);
        check("wrap_w16", 32'(res_count),  32'd17);

        // Asynchronous reset with items in flight
        pulse_reset();
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            a = 8'($urandom); b = 8'($urandom); op = 3'($urandom);
            tick(hs);
        end
        pulse_reset();
        ticks(5);
        check("post_rst_no_stale", 32'(out_valid), 32'd0);

        // Randomized traffic with random back-pressure
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            a = 8'($urandom); b = 8'($urandom); op = 3'($urandom);
            tick(hs);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        ticks(4);
        check("drain_empty", pipe_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
